// File: rtl/grid_io_pkg.sv
// Shared types and constants for the multi-subtile IO grid tile.
// Latency: n/a (types only).
// Backpressure: n/a.
package grid_io_pkg;

  // Bit positions inside one subtile's mode frame
  localparam int CFG_DIR_BIT = 0;
  localparam int CFG_INV_BIT = 1;
  localparam int CFG_REG_BIT = 2;

  // Decoded mode of one subtile (MSB first, so bit 0 is dir)
  typedef struct packed {
    logic reg_in;
    logic inv;
    logic dir;
  } io_mode_t;

  // Configuration counter states
  typedef enum logic {
    ST_PROG = 1'b0,
    ST_DONE = 1'b1
  } cnt_state_t;

endpackage

// File: rtl/grid_io_multi_cfg_if.sv
// Bundle of config-chain, pad-ring and fabric signals of the IO grid tile.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/strobe, no handshake.
interface grid_io_multi_cfg_if #(
  parameter int NUM_IO = 4
);
  logic              ccff_en;
  logic              ccff_head;
  logic              ccff_tail;
  logic              cfg_done;
  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_IN;
  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_OUT;
  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_DIR;
  logic [NUM_IO-1:0] outpad;
  logic [NUM_IO-1:0] inpad;

  // Side that programs the tile and drives pads/fabric
  modport master (
    output ccff_en, ccff_head, gfpga_pad_EMBEDDED_IO_SOC_IN, outpad,
    input  ccff_tail, cfg_done, gfpga_pad_EMBEDDED_IO_SOC_OUT,
           gfpga_pad_EMBEDDED_IO_SOC_DIR, inpad
  );

  // The tile itself
  modport slave (
    input  ccff_en, ccff_head, gfpga_pad_EMBEDDED_IO_SOC_IN, outpad,
    output ccff_tail, cfg_done, gfpga_pad_EMBEDDED_IO_SOC_OUT,
           gfpga_pad_EMBEDDED_IO_SOC_DIR, inpad
  );
endinterface

// File: rtl/grid_io_subtile_cfg.sv
// One IO subtile: mode decode, safe gate, invert, optional input register; macro GRID_IO_SYNC_EN adds a 2-flop pad synchronizer.
// Latency: output path combinational; input path 0/1 cycles (2/3 with GRID_IO_SYNC_EN).
// Backpressure: none; outputs forced to 0 until cfg_done.
module grid_io_subtile_cfg
  import grid_io_pkg::*;
(
  input  logic     prog_clk,
  input  logic     prog_reset_n,
  input  logic     cfg_done,
  input  io_mode_t mode,
  input  logic     soc_in,
  input  logic     outpad,
  output logic     soc_out,
  output logic     soc_dir,
  output logic     inpad
);

  logic pad_in;
  logic in_src;
  logic in_q;

`ifdef GRID_IO_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Two-flop synchronizer bringing the asynchronous pad into prog_clk
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= soc_in;
      sync_q2 <= sync_q1;
    end
  end

  assign pad_in = sync_q2;
`else
  assign pad_in = soc_in;
`endif

  // Inversion sits before the register so both input modes see the same polarity
  assign in_src = pad_in ^ mode.inv;

  // Input capture register used when the registered-input mode bit is set
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_src;
    end
  end

  // Gate everything to a safe 0 until the whole tile is programmed; input path
  // stays live while driving so the pad value reads back
  always_comb begin
    soc_dir = 1'b0;
    soc_out = 1'b0;
    inpad   = 1'b0;
    if (cfg_done) begin
      soc_dir = mode.dir;
      soc_out = mode.dir & (outpad ^ mode.inv);
      inpad   = mode.reg_in ? in_q : in_src;
    end
  end

endmodule

// File: rtl/grid_io_multi_cfg.sv
// NUM_IO IO subtiles behind one ccff chain segment with bit counter and safe-until-configured gate (optional GRID_IO_SYNC_EN pad synchronizer).
// Latency: chain adds NUM_IO*CFG_BITS cycles head->tail; pad/fabric paths as in grid_io_subtile_cfg.
// Backpressure: none; ccff_en=0 simply holds the chain.
module grid_io_multi_cfg
  import grid_io_pkg::*;
#(
  parameter int NUM_IO   = 4,
  parameter int CFG_BITS = 3,
  parameter int CNT_W    = 8
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  grid_io_multi_cfg_if.slave  bus
);

  localparam int L = NUM_IO * CFG_BITS;
  localparam logic [CNT_W-1:0] L_CNT = CNT_W'(L);

  logic [L-1:0]      chain;
  logic [CNT_W-1:0]  count;
  cnt_state_t        state;
  logic              done_q;

  logic [NUM_IO-1:0] soc_out;
  logic [NUM_IO-1:0] soc_dir;
  logic [NUM_IO-1:0] inpad;

  // Config shift register; first bit shifted in ends up in chain[L-1]
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      chain <= '0;
    end else if (bus.ccff_en) begin
      chain <= {chain[L-2:0], bus.ccff_head};
    end
  end

  // Bit counter FSM: count enabled shifts until L, then saturate in DONE
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state  <= ST_PROG;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_PROG: begin
          if (bus.ccff_en) begin
            count <= count + CNT_W'(1);
            if (count == L_CNT - CNT_W'(1)) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          count  <= L_CNT;
          done_q <= 1'b1;
        end
        default: begin
          state  <= ST_PROG;
          count  <= '0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ccff_tail = chain[L-1];
  assign bus.cfg_done  = done_q;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_sub
    io_mode_t mode;

    // Frame i lives at chain[i*CFG_BITS +: CFG_BITS]
    assign mode.dir    = chain[i*CFG_BITS + CFG_DIR_BIT];
    assign mode.inv    = chain[i*CFG_BITS + CFG_INV_BIT];
    assign mode.reg_in = chain[i*CFG_BITS + CFG_REG_BIT];

    grid_io_subtile_cfg u_sub (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .cfg_done     (done_q),
      .mode         (mode),
      .soc_in       (bus.gfpga_pad_EMBEDDED_IO_SOC_IN[i]),
      .outpad       (bus.outpad[i]),
      .soc_out      (soc_out[i]),
      .soc_dir      (soc_dir[i]),
      .inpad        (inpad[i])
    );
  end

  assign bus.gfpga_pad_EMBEDDED_IO_SOC_OUT = soc_out;
  assign bus.gfpga_pad_EMBEDDED_IO_SOC_DIR = soc_dir;
  assign bus.inpad                         = inpad;

endmodule

// File: tb/tb_grid_io_multi_cfg.sv
// Self-checking bench for grid_io_multi_cfg (NUM_IO=4, CFG_BITS=3).
// Table of mode/pad vectors through a scoreboard queue, plus hand sequences.
// Understands GRID_IO_SYNC_EN for the input-path latency checks.
module tb_grid_io_multi_cfg;

`ifdef GRID_IO_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic prog_clk = 1'b0;
  logic prog_reset_n = 1'b0;

  grid_io_multi_cfg_if #(.NUM_IO(4)) bus ();

  grid_io_multi_cfg #(.NUM_IO(4), .CFG_BITS(3), .CNT_W(8)) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .bus          (bus.slave)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic [11:0] cfg;
    logic [3:0]  outpad;
    logic [3:0]  soc_in;
    logic [3:0]  exp_out;
    logic [3:0]  exp_dir;
    logic [3:0]  exp_inpad;
  } vec_t;

  typedef struct {
    logic [3:0] out;
    logic [3:0] dir;
    logic [3:0] inpad;
    logic       done;
  } exp_t;

  vec_t vecs[7];
  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_reset();
    prog_reset_n = 1'b0;
    tick();
    tick();
    prog_reset_n = 1'b1;
  endtask

  task automatic shift_bit(input logic b);
    bus.ccff_en   = 1'b1;
    bus.ccff_head = b;
    tick();
    bus.ccff_en   = 1'b0;
  endtask

  task automatic program_cfg(input logic [11:0] cfg);
    for (int i = 11; i >= 0; i--) shift_bit(cfg[i]);
  endtask

  initial begin
    logic [19:0] pat;
    exp_t e;

    // {cfg, outpad, soc_in, exp_out, exp_dir, exp_inpad}; frames {reg,inv,dir} per subtile, subtile 3 leftmost
    vecs[0] = '{12'h249, 4'b1010, 4'b0000, 4'b1010, 4'b1111, 4'b0000};
    vecs[1] = '{12'h249, 4'b0101, 4'b1100, 4'b0101, 4'b1111, 4'b1100};
    vecs[2] = '{12'h24A, 4'b1111, 4'b0001, 4'b1110, 4'b1110, 4'b0000};
    vecs[3] = '{12'h6DB, 4'b1010, 4'b0011, 4'b0101, 4'b1111, 4'b1100};
    vecs[4] = '{12'h000, 4'b1111, 4'b1010, 4'b0000, 4'b0000, 4'b1010};
    vecs[5] = '{12'hDB6, 4'b1111, 4'b0110, 4'b0000, 4'b0000, 4'b1001};
    vecs[6] = '{12'h8C1, 4'b1111, 4'b1011, 4'b0001, 4'b0101, 4'b1111};

    bus.ccff_en = 1'b0;
    bus.ccff_head = 1'b0;
    bus.outpad = 4'h0;
    bus.gfpga_pad_EMBEDDED_IO_SOC_IN = 4'h0;

    // Reset then idle: everything gated off
    do_reset();
    chk("rst_dir", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'h0);
    chk("rst_out", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_OUT), 32'h0);
    chk("rst_inpad", 32'(bus.inpad), 32'h0);
    chk("rst_done", 32'(bus.cfg_done), 32'h0);
    chk("rst_tail", 32'(bus.ccff_tail), 32'h0);
    bus.gfpga_pad_EMBEDDED_IO_SOC_IN = 4'hF;
    bus.outpad = 4'hF;
    repeat (4) tick();
    chk("idle_inpad", 32'(bus.inpad), 32'h0);
    chk("idle_out", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_OUT), 32'h0);

    // All-output programming: cfg_done rises exactly on the 12th shift, gate holds before
    for (int i = 11; i >= 0; i--) begin
      shift_bit(1'(12'h249 >> i));
      if (i == 5) begin
        chk("mid_gate_dir", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'h0);
        chk("mid_gate_inpad", 32'(bus.inpad), 32'h0);
      end
      if (i == 1) chk("done_at_11", 32'(bus.cfg_done), 32'h0);
      if (i == 0) chk("done_at_12", 32'(bus.cfg_done), 32'h1);
    end
    bus.outpad = 4'b1010;
    #1;
    chk("out_1010", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_OUT), 32'hA);
    chk("dir_all", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'hF);

    // Table vectors: reprogram (legal after DONE), drive, push expectation, settle, pop and compare
    for (int v = 0; v < 7; v++) begin
      program_cfg(vecs[v].cfg);
      bus.outpad = vecs[v].outpad;
      bus.gfpga_pad_EMBEDDED_IO_SOC_IN = vecs[v].soc_in;
      sb_q.push_back('{vecs[v].exp_out, vecs[v].exp_dir, vecs[v].exp_inpad, 1'b1});
      repeat (5) tick();
      if (sb_q.size() == 0) begin
        chk($sformatf("v%0d_sb_empty", v), 32'(sb_q.size()), 32'h1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_out", v), 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_OUT), 32'(e.out));
        chk($sformatf("v%0d_dir", v), 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'(e.dir));
        chk($sformatf("v%0d_inpad", v), 32'(bus.inpad), 32'(e.inpad));
        chk($sformatf("v%0d_done", v), 32'(bus.cfg_done), 32'(e.done));
      end
    end

    // Latency: subtile 2 registered input, subtile 0 combinational input
    program_cfg(12'h100);
    bus.gfpga_pad_EMBEDDED_IO_SOC_IN = 4'h0;
    repeat (4) tick();
    bus.gfpga_pad_EMBEDDED_IO_SOC_IN = 4'b0101;
    #1;
    for (int e2 = 0; e2 <= 3; e2++) begin
      if (e2 > 0) tick();
      chk($sformatf("lat_comb_e%0d", e2), 32'(bus.inpad[0]), 32'(e2 >= SYNC_LAT));
      chk($sformatf("lat_reg_e%0d", e2), 32'(bus.inpad[2]), 32'(e2 >= SYNC_LAT + 1));
    end

    // Pass-through: tail after edge n (n>=12) is bit n-11 in shift order
    do_reset();
    pat = 20'hB3C5A;
    for (int n = 1; n <= 20; n++) begin
      shift_bit(pat[20-n]);
      if (n < 12) chk($sformatf("pt_tail_%0d", n), 32'(bus.ccff_tail), 32'h0);
      else        chk($sformatf("pt_tail_%0d", n), 32'(bus.ccff_tail), 32'(pat[31-n]));
      chk($sformatf("pt_done_%0d", n), 32'(bus.cfg_done), 32'(n >= 12));
    end
    bus.ccff_en = 1'b0;
    repeat (3) tick();
    chk("pt_hold_tail", 32'(bus.ccff_tail), 32'(pat[11]));

    // Reset mid-shift clears counter and chain; a full re-shift is needed
    do_reset();
    for (int n = 0; n < 6; n++) shift_bit(1'b1);
    prog_reset_n = 1'b0;
    tick();
    prog_reset_n = 1'b1;
    chk("abort_done", 32'(bus.cfg_done), 32'h0);
    chk("abort_tail", 32'(bus.ccff_tail), 32'h0);
    for (int n = 0; n < 11; n++) shift_bit(1'b1);
    chk("abort_done_11", 32'(bus.cfg_done), 32'h0);
    chk("abort_tail_11", 32'(bus.ccff_tail), 32'h0);
    shift_bit(1'b1);
    chk("abort_done_12", 32'(bus.cfg_done), 32'h1);
    chk("abort_tail_12", 32'(bus.ccff_tail), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
